// File: rtl/hls_run_pkg.sv
// rtl/hls_run_pkg.sv - shared state and status encodings for the HLS run sequencer
package hls_run_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DUT_RST = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_REPORT  = 3'd4
    } run_state_t;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_TIMEOUT  = 2'd1,
        ST_SPURIOUS = 2'd2
    } status_t;

endpackage

// File: rtl/hls_cycle_counter.sv
// rtl/hls_cycle_counter.sv - per-run latency counter: load 1, increment, saturate at MAX_CYCLES
module hls_cycle_counter #(
    parameter int          CYCLE_W    = 32,
    parameter int unsigned MAX_CYCLES = 200000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               inc,
    output logic [CYCLE_W-1:0] cnt,
    output logic               at_limit
);

    localparam logic [CYCLE_W-1:0] LIMIT = CYCLE_W'(MAX_CYCLES);

    assign at_limit = (cnt == LIMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CYCLE_W'(1);
        end else if (inc && !at_limit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hls_run_sequencer.sv
// rtl/hls_run_sequencer.sv - back-to-back run harness for a start/done HLS core; HLS_RUN_STATS_EN adds latency stats and held-done detection
module hls_run_sequencer
    import hls_run_pkg::*;
#(
    parameter int          CYCLE_W        = 32,
    parameter int          RUN_W          = 8,
    parameter int unsigned MAX_CYCLES     = 200000000,
    parameter int          DUT_RST_CYCLES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               go,
    input  logic [RUN_W-1:0]   num_runs,
    output logic               dut_reset_n,
    output logic               dut_start_port,
    input  logic               dut_done_port,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [RUN_W-1:0]   res_run_idx,
    output logic [1:0]         res_status,
    output logic [CYCLE_W-1:0] res_cycles,
    output logic               busy,
    output logic               batch_done,
    output logic               batch_fail
`ifdef HLS_RUN_STATS_EN
    ,
    output logic [CYCLE_W-1:0]       stat_min,
    output logic [CYCLE_W-1:0]       stat_max,
    output logic [CYCLE_W+RUN_W-1:0] stat_sum
`endif
);

    typedef struct packed {
        logic [RUN_W-1:0]   run_idx;
        status_t            status;
        logic [CYCLE_W-1:0] cycles;
    } res_rec_t;

    localparam logic [3:0]         RST_LAST = 4'(DUT_RST_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] LIMIT    = CYCLE_W'(MAX_CYCLES);

    run_state_t         state, state_next;
    res_rec_t           rec;
    logic [3:0]         rst_cnt;
    logic [RUN_W-1:0]   runs_q;
    logic [RUN_W-1:0]   run_idx;
    logic [CYCLE_W-1:0] cnt;
    logic               at_limit;
    logic               cnt_load;
    logic               cnt_inc;
    logic               accept;
    logic               last_run;
    logic               chk_pending;

    hls_cycle_counter #(
        .CYCLE_W    (CYCLE_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_cycle_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .inc      (cnt_inc),
        .cnt      (cnt),
        .at_limit (at_limit)
    );

    assign res_run_idx = rec.run_idx;
    assign res_status  = rec.status;
    assign res_cycles  = rec.cycles;
    assign last_run    = (run_idx == runs_q - RUN_W'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_load       = 1'b0;
        cnt_inc        = 1'b0;
        busy           = (state != S_IDLE);
        dut_reset_n    = (state == S_START) || (state == S_WAIT);
        dut_start_port = (state == S_START);
        // The first REPORT cycle after a done is spent watching for a held done.
        res_valid      = (state == S_REPORT) && !chk_pending;
        accept         = res_valid && res_ready;
        case (state)
            S_IDLE:    if (go && num_runs != '0) state_next = S_DUT_RST;
            S_DUT_RST: if (rst_cnt == RST_LAST) state_next = S_START;
            S_START: begin
                cnt_load   = 1'b1;
                state_next = dut_done_port ? S_REPORT : S_WAIT;
            end
            S_WAIT: begin
                cnt_inc = 1'b1;
                if (dut_done_port || at_limit) state_next = S_REPORT;
            end
            S_REPORT: begin
                if (accept) begin
                    if (rec.status == ST_TIMEOUT || last_run) state_next = S_IDLE;
                    else state_next = S_DUT_RST;
                end
            end
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rst_cnt     <= '0;
            runs_q      <= '0;
            run_idx     <= '0;
            rec         <= '0;
            batch_done  <= 1'b0;
            batch_fail  <= 1'b0;
            chk_pending <= 1'b0;
`ifdef HLS_RUN_STATS_EN
            stat_min    <= '0;
            stat_max    <= '0;
            stat_sum    <= '0;
`endif
        end else begin
            batch_done  <= 1'b0;
            chk_pending <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        runs_q     <= num_runs;
                        run_idx    <= '0;
                        rst_cnt    <= '0;
                        batch_fail <= 1'b0;
                        batch_done <= (num_runs == '0);
`ifdef HLS_RUN_STATS_EN
                        stat_min   <= '1;
                        stat_max   <= '0;
                        stat_sum   <= '0;
`endif
                    end
                end
                S_DUT_RST: rst_cnt <= rst_cnt + 1'b1;
                S_START: begin
                    if (dut_done_port) begin
                        rec.run_idx <= run_idx;
                        rec.status  <= ST_OK;
                        rec.cycles  <= CYCLE_W'(1);
                    end
                end
                S_WAIT: begin
                    // Done wins over a coincident timeout.
                    if (dut_done_port) begin
                        rec.run_idx <= run_idx;
                        rec.status  <= ST_OK;
                        rec.cycles  <= cnt + 1'b1;
`ifdef HLS_RUN_STATS_EN
                        chk_pending <= 1'b1;
`endif
                    end else if (at_limit) begin
                        rec.run_idx <= run_idx;
                        rec.status  <= ST_TIMEOUT;
                        rec.cycles  <= LIMIT;
                    end
                end
                S_REPORT: begin
`ifdef HLS_RUN_STATS_EN
                    if (chk_pending && dut_done_port) rec.status <= ST_SPURIOUS;
`endif
                    if (accept) begin
                        if (rec.status != ST_OK) batch_fail <= 1'b1;
                        if (state_next == S_IDLE) begin
                            batch_done <= 1'b1;
                        end else begin
                            run_idx <= run_idx + 1'b1;
                            rst_cnt <= '0;
                        end
`ifdef HLS_RUN_STATS_EN
                        if (rec.status == ST_OK) begin
                            if (rec.cycles < stat_min) stat_min <= rec.cycles;
                            if (rec.cycles > stat_max) stat_max <= rec.cycles;
                            stat_sum <= stat_sum + {{RUN_W{1'b0}}, rec.cycles};
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
